// File: rtl/cp0_unit.sv
// cp0_unit: system-control coprocessor for cpu55 (Status, Cause, EPC,
// BadVAddr, Count, Compare) with exception/interrupt arbitration.
//
// Ports:
//   clk, rst        core clock, synchronous active-low reset
//   mfc0/mtc0/eret  instruction class of the current core instruction
//   rd, reg_in      CP0 register number and MTC0 write data
//   reg_out         MFC0 read data (0 when mfc0 is low)
//   npc_in          return address captured into EPC on entry
//   exc_valid/code  synchronous exception raised by the current instruction
//   bad_addr        faulting address for address-error exceptions
//   hw_int          level-sensitive external interrupt lines
//   epc             current EPC, used by the core for ERET redirect
//   exc_pc_sel      redirect the PC to exc_pc this cycle
//   exc_pc          exception vector
//   int_pending     any enabled interrupt pending (Cause.IP & Status.IM)
module cp0_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0008,
    parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mfc0,
    input  logic        mtc0,
    input  logic        eret,
    input  logic [4:0]  rd,
    input  logic [31:0] reg_in,
    output logic [31:0] reg_out,
    input  logic [31:0] npc_in,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] bad_addr,
    input  logic [4:0]  hw_int,
    output logic [31:0] epc,
    output logic        exc_pc_sel,
    output logic [31:0] exc_pc,
    output logic        int_pending
);

    localparam logic [4:0] R_BADVADDR = 5'd8;
    localparam logic [4:0] R_COUNT    = 5'd9;
    localparam logic [4:0] R_COMPARE  = 5'd11;
    localparam logic [4:0] R_STATUS   = 5'd12;
    localparam logic [4:0] R_CAUSE    = 5'd13;
    localparam logic [4:0] R_EPC      = 5'd14;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;

    logic [31:0] status_d;
    logic [31:0] cause_d;
    logic [31:0] epc_d;
    logic [31:0] badvaddr_d;
    logic [31:0] count_d;
    logic [31:0] compare_d;

    logic ie;
    logic exl;
    logic take_exc;
    logic take_int;
    logic take;
    logic do_eret;
    logic wr_en;
    logic timer_hit;

    assign ie  = status_q[0];
    assign exl = status_q[1];

    assign int_pending = |(cause_q[15:8] & status_q[15:8]);

    assign take_exc = exc_valid & ~exl;
    assign take_int = ~exc_valid & ie & ~exl & int_pending;
    assign take     = take_exc | take_int;

    // A taken trap swallows this cycle's eret/mtc0; eret beats mtc0.
    assign do_eret = eret & ~take;
    assign wr_en   = mtc0 & ~take & ~eret;

    assign exc_pc_sel = take;
    assign exc_pc     = EXC_VECTOR;
    assign epc        = epc_q;

    always_comb begin
        reg_out = 32'h0;
        if (mfc0) begin
            case (rd)
                R_BADVADDR: reg_out = badvaddr_q;
                R_COUNT:    reg_out = count_q;
                R_COMPARE:  reg_out = compare_q;
                R_STATUS:   reg_out = status_q;
                R_CAUSE:    reg_out = cause_q;
                R_EPC:      reg_out = epc_q;
                default:    reg_out = 32'h0;
            endcase
        end
    end

    always_comb begin
        count_d = count_q + 32'd1;
        if (wr_en && rd == R_COUNT) begin
            count_d = reg_in;
        end
    end

    // Timer match is judged against the value Count takes at this edge.
    assign timer_hit = (count_d == compare_q);

    always_comb begin
        compare_d = compare_q;
        if (wr_en && rd == R_COMPARE) begin
            compare_d = reg_in;
        end
    end

    always_comb begin
        cause_d = cause_q;
        cause_d[14:10] = hw_int;
        if (wr_en && rd == R_COMPARE) begin
            cause_d[15] = 1'b0;
        end else if (timer_hit) begin
            cause_d[15] = 1'b1;
        end
        if (take_exc) begin
            cause_d[6:2] = exc_code;
        end else if (take_int) begin
            cause_d[6:2] = 5'd0;
        end else if (wr_en && rd == R_CAUSE) begin
            cause_d[9:8] = reg_in[9:8];
        end
    end

    always_comb begin
        status_d = status_q;
        if (take) begin
            status_d[1] = 1'b1;
        end else if (do_eret) begin
            status_d[1] = 1'b0;
        end else if (wr_en && rd == R_STATUS) begin
            status_d = (status_q & ~STATUS_WMASK)
                     | (reg_in & STATUS_WMASK);
        end
    end

    always_comb begin
        epc_d = epc_q;
        if (take) begin
            epc_d = npc_in;
        end else if (wr_en && rd == R_EPC) begin
            epc_d = reg_in;
        end
    end

    always_comb begin
        badvaddr_d = badvaddr_q;
        if (take_exc &&
            (exc_code == EXC_ADEL || exc_code == EXC_ADES)) begin
            badvaddr_d = bad_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            status_q   <= STATUS_RST;
            cause_q    <= 32'h0;
            epc_q      <= 32'h0;
            badvaddr_q <= 32'h0;
            count_q    <= 32'h0;
            compare_q  <= 32'hFFFF_FFFF;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
        end
    end

endmodule
